// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the dot-product sequencer: state encoding,
// drain length and default widths.
package mac_ctrl_pkg;

  localparam int BITWIDTH_DEF = 32;
  localparam int ADDR_W_DEF   = 6;
  localparam int RESULT_W     = 2 * BITWIDTH_DEF;

  // Cycles spent after the last read before the result is captured:
  // one for the RAM read latency, one for the MAC update.
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_addr_gen.sv
// Running address generator for the A/B operand RAMs. Loads base addresses,
// B stride and a saturated element count, then advances one element per step.
// The B address is accumulated by addition so no multiplier is needed.
module mac_addr_gen #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] b_stride,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              last
);

  logic [ADDR_W:0]   max_len;
  logic [ADDR_W:0]   len_sat;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] stride_q;

  // Largest vector the address space can hold; longer requests are clipped.
  assign max_len = {1'b1, {ADDR_W{1'b0}}};
  assign len_sat = (len > max_len) ? max_len : len;

  // The element being addressed now is the final one of the vector.
  assign last = (remaining == (ADDR_W+1)'(1));

  // Address and count registers; addresses wrap modulo the RAM depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_addr    <= '0;
      b_addr    <= '0;
      stride_q  <= '0;
      remaining <= '0;
    end else if (load) begin
      a_addr    <= a_base;
      b_addr    <= b_base;
      stride_q  <= b_stride;
      remaining <= len_sat;
    end else if (step) begin
      a_addr    <= a_addr + ADDR_W'(1);
      b_addr    <= b_addr + stride_q;
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: reads len operand pairs from the A/B RAMs, streams
// them into an external MAC and captures the accumulated result.
//
// Handshakes:
//   start/done : start is taken only while idle (busy low); the job ends with
//                a single-cycle done pulse, result already valid in that cycle.
//   rd_en/rdata: a RAM read issued in cycle t returns data in cycle t+1;
//                mac_en marks the cycle that data is presented to the MAC.
module mac_dot_seq
  import mac_ctrl_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W:0]       len,
  input  logic [ADDR_W-1:0]     a_base,
  input  logic [ADDR_W-1:0]     b_base,
  input  logic [ADDR_W-1:0]     b_stride,
  output logic                  busy,
  output logic                  done,
  output logic [2*BITWIDTH-1:0] result,
  output logic [ADDR_W-1:0]     a_addr,
  output logic                  a_rd_en,
  input  logic [BITWIDTH-1:0]   a_rdata,
  output logic [ADDR_W-1:0]     b_addr,
  output logic                  b_rd_en,
  input  logic [BITWIDTH-1:0]   b_rdata,
  output logic [BITWIDTH-1:0]   mac_ain,
  output logic [BITWIDTH-1:0]   mac_bin,
  output logic                  mac_en,
  output logic                  mac_first,
  input  logic [2*BITWIDTH-1:0] mac_dout,
  output logic [1:0]            state_dbg
);

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  fetching;
  logic                  ag_last;
  logic                  drain_last;
  logic [1:0]            drain_cnt;
  logic                  first_pend;
  logic                  mac_en_q;
  logic                  mac_first_q;
  logic                  done_q;
  logic [2*BITWIDTH-1:0] result_q;

  assign accept     = (state == IDLE) && start;
  assign fetching   = (state == FETCH);
  assign drain_last = (drain_cnt == 2'(DRAIN_CYCLES - 1));
  assign state_dbg  = state;

  mac_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (fetching),
    .a_base   (a_base),
    .b_base   (b_base),
    .b_stride (b_stride),
    .len      (len),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .last     (ag_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an empty vector skips straight to DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = (len == '0) ? DONE : FETCH;
      FETCH: begin
        if (abort)        state_nxt = IDLE;
        else if (ag_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)           state_nxt = IDLE;
        else if (drain_last) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: reads are issued on every FETCH cycle.
  always_comb begin
    busy    = (state != IDLE);
    a_rd_en = fetching;
    b_rd_en = fetching;
  end

  // Counts cycles spent in DRAIN so the capture lands after the last MAC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              drain_cnt <= '0;
    else if (state != DRAIN) drain_cnt <= '0;
    else                     drain_cnt <= drain_cnt + 2'd1;
  end

  // MAC valid pipeline: mac_en follows the read enable by the RAM latency;
  // first_pend marks the k = 0 read so only that beat restarts the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_pend  <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
    end else begin
      mac_en_q    <= fetching && !abort;
      mac_first_q <= fetching && first_pend && !abort;
      if (accept)        first_pend <= 1'b1;
      else if (fetching) first_pend <= 1'b0;
    end
  end

  // Result capture: cleared for an empty vector, otherwise sampled from the
  // MAC on the last DRAIN cycle; an abort leaves the previous result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (accept && (len == '0)) begin
      result_q <= '0;
    end else if ((state == DRAIN) && drain_last && !abort) begin
      result_q <= mac_dout;
    end
  end

  // Registered completion pulse, high for the single DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= (state_nxt == DONE);
  end

  assign done      = done_q;
  assign result    = result_q;
  assign mac_en    = mac_en_q;
  assign mac_first = mac_first_q;
  // Operands pass straight from the RAMs; held at zero when the MAC is idle.
  assign mac_ain   = mac_en_q ? a_rdata : '0;
  assign mac_bin   = mac_en_q ? b_rdata : '0;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq with behavioural 1-cycle operand RAMs and a MAC.
module tb_mac_dot_seq;

  localparam int BW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int FAR   = 32'h3fff_ffff;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, abort;
  logic [AW:0]     len;
  logic [AW-1:0]   a_base, b_base, b_stride;
  logic            busy, done;
  logic [2*BW-1:0] result;
  logic [AW-1:0]   a_addr, b_addr;
  logic            a_rd_en, b_rd_en;
  logic [BW-1:0]   a_rdata, b_rdata;
  logic [BW-1:0]   mac_ain, mac_bin;
  logic            mac_en, mac_first;
  logic [2*BW-1:0] mac_dout;
  logic [1:0]      state_dbg;

  logic [BW-1:0]   a_mem [DEPTH];
  logic [BW-1:0]   b_mem [DEPTH];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mac_dot_seq #(.BITWIDTH(BW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .a_base(a_base), .b_base(b_base), .b_stride(b_stride),
    .busy(busy), .done(done), .result(result),
    .a_addr(a_addr), .a_rd_en(a_rd_en), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_rd_en(b_rd_en), .b_rdata(b_rdata),
    .mac_ain(mac_ain), .mac_bin(mac_bin), .mac_en(mac_en),
    .mac_first(mac_first), .mac_dout(mac_dout), .state_dbg(state_dbg)
  );

  // Behavioural operand RAMs, one cycle read latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_rd_en) a_rdata <= a_mem[a_addr];
      if (b_rd_en) b_rdata <= b_mem[b_addr];
    end
  end

  // Behavioural MAC: load on mac_first, accumulate otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mac_dout <= '0;
    else if (mac_en)
      mac_dout <= mac_first ? (64'(mac_ain) * 64'(mac_bin))
                            : (mac_dout + 64'(mac_ain) * 64'(mac_bin));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One job at a time, described by its accept cycle and parameters; every
  // expected output is a function of the cycle offset from acceptance.
  int          cyc;
  bit          have_job, aborted;
  int          t0, jl, ja, jb, js, ta;
  logic [63:0] exp_result;
  logic [63:0] exp_q[$];

  function automatic int sat_len(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic logic [63:0] dot(input int l, input int ab, input int bb, input int bs);
    logic [63:0] s;
    s = '0;
    for (int k = 0; k < l; k++)
      s = s + 64'(a_mem[(ab + k) % DEPTH]) * 64'(b_mem[(bb + k * bs) % DEPTH]);
    return s;
  endfunction

  function automatic int done_cyc();
    return (jl == 0) ? t0 + 1 : t0 + jl + 3;
  endfunction

  function automatic bit m_busy(input int n);
    int endc;
    endc = aborted ? ta : done_cyc();
    return have_job && (n > t0) && (n <= endc);
  endfunction

  function automatic bit m_in_work(input int n);
    return have_job && !aborted && (jl > 0) && (n >= t0 + 1) && (n <= t0 + jl + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc        <= 0;
      have_job   <= 1'b0;
      aborted    <= 1'b0;
      exp_result <= '0;
      exp_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (start && !m_busy(cyc)) begin
        have_job <= 1'b1;
        aborted  <= 1'b0;
        t0       <= cyc;
        jl       <= sat_len(int'(len));
        ja       <= int'(a_base);
        jb       <= int'(b_base);
        js       <= int'(b_stride);
        exp_q.push_back(dot(sat_len(int'(len)), int'(a_base), int'(b_base), int'(b_stride)));
        if (len == '0) exp_result <= '0;
      end else if (abort && m_in_work(cyc)) begin
        aborted <= 1'b1;
        ta      <= cyc;
        void'(exp_q.pop_back());
      end else if (have_job && !aborted && (jl > 0) && (cyc == t0 + jl + 2)) begin
        exp_result <= dot(jl, ja, jb, js);
      end
    end
  end

  // ---------------- compare process + monitor ----------------
  int      rd_cnt = 0, mac_cnt = 0, first_cnt = 0, done_cnt = 0;
  int      a_log[$];
  int      b_log[$];

  always @(negedge clk) begin
    int          n, lim, k;
    bit          e_rd, e_mac;
    logic [63:0] sb;
    n     = cyc;
    lim   = aborted ? ta : FAR;
    e_rd  = have_job && (jl > 0) && (n >= t0 + 1) && (n <= t0 + jl) && (n <= lim);
    e_mac = have_job && (jl > 0) && (n >= t0 + 2) && (n <= t0 + jl + 1) && (n <= lim);
    chk("busy",      64'(busy),      64'(m_busy(n)));
    chk("a_rd_en",   64'(a_rd_en),   64'(e_rd));
    chk("b_rd_en",   64'(b_rd_en),   64'(e_rd));
    chk("mac_en",    64'(mac_en),    64'(e_mac));
    chk("mac_first", 64'(mac_first), 64'(e_mac && (n == t0 + 2)));
    chk("done",      64'(done),      64'(have_job && !aborted && (n == done_cyc())));
    chk("result",    result,         exp_result);
    if (e_rd) begin
      k = n - t0 - 1;
      chk("a_addr", 64'(a_addr), 64'((ja + k) % DEPTH));
      chk("b_addr", 64'(b_addr), 64'((jb + k * js) % DEPTH));
    end
    if (e_mac) begin
      k = n - t0 - 2;
      chk("mac_ain", 64'(mac_ain), 64'(a_mem[(ja + k) % DEPTH]));
      chk("mac_bin", 64'(mac_bin), 64'(b_mem[(jb + k * js) % DEPTH]));
    end else begin
      chk("mac_ain_idle", 64'(mac_ain), 64'(0));
      chk("mac_bin_idle", 64'(mac_bin), 64'(0));
    end
    if (done) begin
      chk("sb_depth", 64'(exp_q.size()), 64'(1));
      if (exp_q.size() > 0) begin
        sb = exp_q.pop_front();
        chk("sb_result", result, sb);
      end
      done_cnt++;
    end
    if (a_rd_en) begin
      rd_cnt++;
      a_log.push_back(int'(a_addr));
      b_log.push_back(int'(b_addr));
    end
    if (mac_en)    mac_cnt++;
    if (mac_first) first_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int l, input int ab, input int bb, input int bs);
    len      = (AW+1)'(l);
    a_base   = AW'(ab);
    b_base   = AW'(bb);
    b_stride = AW'(bs);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Returns cycles from accept to done; on timeout the final done check fails.
  task automatic wait_done(input int budget, output int n);
    n = 1;
    while (!done && (n < budget)) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n, s_rd, s_mac, s_first, s_done, s_log;
    int ea[3];
    int eb[3];
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    len = '0; a_base = '0; b_base = '0; b_stride = '0;
    for (int i = 0; i < DEPTH; i++) begin
      a_mem[i] = BW'(i + 1);
      b_mem[i] = BW'(2 * i + 1);
    end
    repeat (3) tick();
    chk("rst_busy",   64'(busy),    64'(0));
    chk("rst_done",   64'(done),    64'(0));
    chk("rst_result", result,       64'(0));
    chk("rst_rd_en",  64'(a_rd_en), 64'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // len=4, A=[1,2,3,4], B=[5,6,7,8] -> 70 after 7 cycles, one first beat
    for (int i = 0; i < 4; i++) begin
      a_mem[i] = BW'(i + 1);
      b_mem[i] = BW'(i + 5);
    end
    s_first = first_cnt;
    start_job(4, 0, 0, 1);
    wait_done(40, n);
    chk("len4_latency", 64'(n), 64'(7));
    chk("len4_result", result, 64'd70);
    chk("len4_first_cnt", 64'(first_cnt - s_first), 64'(1));
    repeat (2) tick();

    // address wrap and strided B walk
    a_mem[62] = 32'd3;  a_mem[63] = 32'd5; a_mem[0]  = 32'd7;
    b_mem[1]  = 32'd11; b_mem[9]  = 32'd13; b_mem[17] = 32'd2;
    ea = '{62, 63, 0};
    eb = '{1, 9, 17};
    s_log = a_log.size();
    start_job(3, 62, 1, 8);
    wait_done(40, n);
    chk("wrap_latency", 64'(n), 64'(6));
    chk("wrap_result", result, 64'd112);
    chk("wrap_nreads", 64'(a_log.size() - s_log), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (s_log + i < a_log.size()) begin
        chk("wrap_a_addr", 64'(a_log[s_log + i]), 64'(ea[i]));
        chk("wrap_b_addr", 64'(b_log[s_log + i]), 64'(eb[i]));
      end
    end
    repeat (2) tick();

    // len=0: immediate done, result cleared, no RAM/MAC activity
    s_rd = rd_cnt; s_mac = mac_cnt;
    start_job(0, 5, 5, 1);
    wait_done(10, n);
    chk("len0_latency", 64'(n), 64'(1));
    chk("len0_result", result, 64'd0);
    repeat (3) tick();
    chk("len0_rd_cnt", 64'(rd_cnt - s_rd), 64'(0));
    chk("len0_mac_cnt", 64'(mac_cnt - s_mac), 64'(0));

    // start held every cycle of a len=5 job, including the done cycle
    for (int i = 0; i < 5; i++) begin
      a_mem[i]      = BW'(i + 1);
      b_mem[10 + i] = 32'd2;
    end
    s_done = done_cnt;
    len = 7'd5; a_base = 6'd0; b_base = 6'd10; b_stride = 6'd1;
    start = 1'b1;
    repeat (8) tick();
    chk("hold_done_cycle", 64'(done), 64'(1));
    tick();
    start = 1'b0;
    chk("hold_busy_after", 64'(busy), 64'(0));
    chk("hold_done_count", 64'(done_cnt - s_done), 64'(1));
    chk("hold_result", result, 64'd30);
    repeat (3) tick();
    chk("hold_no_restart", 64'(busy), 64'(0));

    // abort in the 3rd FETCH cycle of len=8, then a clean len=2 job
    s_done = done_cnt;
    start_job(8, 0, 20, 1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_rd_en", 64'(a_rd_en), 64'(0));
    chk("abort_mac_en", 64'(mac_en), 64'(0));
    repeat (15) tick();
    chk("abort_no_done", 64'(done_cnt - s_done), 64'(0));
    chk("abort_result_kept", result, 64'd30);
    a_mem[30] = 32'd2; a_mem[31] = 32'd2;
    b_mem[40] = 32'd3; b_mem[41] = 32'd3;
    start_job(2, 30, 40, 1);
    wait_done(40, n);
    chk("post_abort_latency", 64'(n), 64'(5));
    chk("post_abort_result", result, 64'd12);
    repeat (2) tick();

    // asynchronous reset in the middle of DRAIN
    start_job(3, 0, 0, 1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",      64'(busy),      64'(0));
    chk("arst_done",      64'(done),      64'(0));
    chk("arst_result",    result,         64'(0));
    chk("arst_a_rd_en",   64'(a_rd_en),   64'(0));
    chk("arst_b_rd_en",   64'(b_rd_en),   64'(0));
    chk("arst_mac_en",    64'(mac_en),    64'(0));
    chk("arst_mac_first", 64'(mac_first), 64'(0));
    chk("arst_a_addr",    64'(a_addr),    64'(0));
    chk("arst_b_addr",    64'(b_addr),    64'(0));
    chk("arst_mac_ain",   64'(mac_ain),   64'(0));
    chk("arst_mac_bin",   64'(mac_bin),   64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    a_mem[50] = 32'd4; a_mem[51] = 32'd5;
    b_mem[50] = 32'd6; b_mem[51] = 32'd7;
    start_job(2, 50, 50, 1);
    wait_done(40, n);
    chk("post_rst_result", result, 64'd59);
    repeat (2) tick();

    // full-width operands
    a_mem[0] = 32'hFFFF_FFFF; a_mem[1] = 32'hFFFF_FFFF;
    b_mem[0] = 32'hFFFF_FFFF; b_mem[1] = 32'hFFFF_FFFF;
    start_job(2, 0, 0, 1);
    wait_done(40, n);
    chk("wide_result", result, 64'hFFFF_FFFC_0000_0002);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
